// File: rtl/rules_pkg.sv
// Shared types and constants for the rules checker and its arbiter.
// Op codes, requester ids, owner encoding and small decode helpers.
package rules_pkg;

  localparam int N_REQ = 3;

  typedef enum logic [1:0] {
    OP_RESET  = 2'b00,
    OP_UPDATE = 2'b01,
    OP_ERASE  = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE,
    ST_SETTLE
  } arb_state_e;

  typedef logic [1:0] color_t;

  localparam logic [1:0] REQ_PLAYER = 2'd0;
  localparam logic [1:0] REQ_SOLVER = 2'd1;
  localparam logic [1:0] REQ_CHAL   = 2'd2;
  localparam logic [1:0] OWNER_NONE = 2'd3;

  // One-hot decode of a requester id; OWNER_NONE decodes to zero.
  function automatic logic [N_REQ-1:0] idx_onehot(
    input logic [1:0] idx
  );
    logic [N_REQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (int'(idx) == i) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  // Lock priority: solver, then challenge, then player.
  function automatic logic [1:0] lock_pick(
    input logic [N_REQ-1:0] req
  );
    if (req[REQ_SOLVER]) return REQ_SOLVER;
    if (req[REQ_CHAL]) return REQ_CHAL;
    return REQ_PLAYER;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Grants the first set mask bit strictly after ptr, wrapping.
module rr_pick #(
  parameter int N = 3,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt
);

  // Scan from ptr+1 around to ptr, keep the first hit.
  always_comb begin
    int  idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && mask[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rules_arbiter.sv
// Arbiter sharing the rules checker command port among requesters.
// Serialises commands, supports port locking, filters illegal ops.
module rules_arbiter
  import rules_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   cmd_valid,
  input  logic [2*N_REQ-1:0] cmd_op,
  input  logic [2*N_REQ-1:0] cmd_color,
  output logic [N_REQ-1:0]   cmd_ready,
  output logic [N_REQ-1:0]   cmd_done,
  output logic [N_REQ-1:0]   cmd_rej,
  input  logic [N_REQ-1:0]   lock_req,
  output logic [N_REQ-1:0]   lock_gnt,
  input  logic               fsm_full,
  input  logic               fsm_empty,
  output logic               fsm_reset,
  output logic               fsm_update,
  output logic               fsm_erase,
  output logic [1:0]         fsm_color
);

  arb_state_e       state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       fly_q, fly_d;
  logic             fly_rej_q, fly_rej_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [N_REQ-1:0] rej_q, rej_d;
  logic             rst_q, rst_d;
  logic             upd_q, upd_d;
  logic             era_q, era_d;
  color_t           color_q, color_d;

  logic             idle;
  logic             acquire;
  logic             accept;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] pick;
  logic [N_REQ-1:0] own_oh;
  logic [1:0]       win_idx;
  op_e              win_op;
  color_t           win_color;
  logic             rej_now;

  assign idle    = (state_q == ST_IDLE);
  assign own_oh  = idx_onehot(owner_q);
  assign acquire = idle && (owner_q == OWNER_NONE)
                   && (|lock_req);
  assign elig    = (owner_q == OWNER_NONE)
                   ? cmd_valid : (cmd_valid & own_oh);

  rr_pick #(.N(N_REQ)) u_pick (
    .mask (elig),
    .ptr  (ptr_q),
    .gnt  (pick)
  );

  assign cmd_ready = (idle && !acquire) ? pick : '0;
  assign accept    = |cmd_ready;

  // Mux out the winning requester's id, op and color.
  always_comb begin
    win_idx   = 2'd0;
    win_op    = OP_RESET;
    win_color = 2'b00;
    for (int i = 0; i < N_REQ; i++) begin
      if (cmd_ready[i]) begin
        win_idx   = 2'(i);
        win_op    = op_e'(cmd_op[2*i +: 2]);
        win_color = cmd_color[2*i +: 2];
      end
    end
  end

  // Filter: ops the checker status makes illegal.
  always_comb begin
    rej_now = 1'b0;
    unique case (win_op)
      OP_UPDATE: rej_now = fsm_full;
      OP_ERASE:  rej_now = fsm_empty;
      OP_RSVD:   rej_now = 1'b1;
      default:   rej_now = 1'b0;
    endcase
  end

  // Next-state: FSM, lock ownership, pointer and output pulses.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    fly_d     = fly_q;
    fly_rej_d = fly_rej_q;
    done_d    = '0;
    rej_d     = '0;
    rst_d     = 1'b0;
    upd_d     = 1'b0;
    era_d     = 1'b0;
    color_d   = color_q;
    unique case (state_q)
      ST_IDLE: begin
        if (acquire) begin
          owner_d = lock_pick(lock_req);
        end else if (owner_q != OWNER_NONE
                     && (lock_req & own_oh) == '0) begin
          owner_d = OWNER_NONE;
        end
        if (accept) begin
          state_d   = ST_SETTLE;
          ptr_d     = win_idx;
          fly_d     = win_idx;
          fly_rej_d = rej_now;
          if (!rej_now) begin
            color_d = win_color;
            unique case (win_op)
              OP_RESET:  rst_d = 1'b1;
              OP_UPDATE: upd_d = 1'b1;
              OP_ERASE:  era_d = 1'b1;
              default:   ;
            endcase
          end
        end
      end
      ST_SETTLE: begin
        state_d = ST_IDLE;
        done_d  = idx_onehot(fly_q);
        rej_d   = fly_rej_q ? idx_onehot(fly_q) : '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset also clears the checker.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWNER_NONE;
      ptr_q     <= 2'(N_REQ-1);
      fly_q     <= 2'd0;
      fly_rej_q <= 1'b0;
      done_q    <= '0;
      rej_q     <= '0;
      rst_q     <= 1'b1;
      upd_q     <= 1'b0;
      era_q     <= 1'b0;
      color_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      fly_q     <= fly_d;
      fly_rej_q <= fly_rej_d;
      done_q    <= done_d;
      rej_q     <= rej_d;
      rst_q     <= rst_d;
      upd_q     <= upd_d;
      era_q     <= era_d;
      color_q   <= color_d;
    end
  end

  assign cmd_done   = done_q;
  assign cmd_rej    = rej_q;
  assign lock_gnt   = own_oh;
  assign fsm_reset  = rst_q;
  assign fsm_update = upd_q;
  assign fsm_erase  = era_q;
  assign fsm_color  = color_q;

  // A pending command must stay valid until it is accepted.
  for (genvar g = 0; g < N_REQ; g++) begin : g_hold
    a_hold: assert property (@(posedge clk) disable iff (reset)
      (cmd_valid[g] && !cmd_ready[g]) |=> cmd_valid[g]);
  end

endmodule

// File: doc/rules_arbiter.md
# rules_arbiter

Shares the single command port of the `rules` sequence checker among up to three requesters: player input, solver and challenge sequencer. Each requester sees the checker as its own. The block serialises commands and optionally locks the port to one owner for multi-command runs such as a solver search. It filters commands that the checker's full/empty status makes illegal, and tells each requester when the checker's status outputs reflect its command. It sits between the game controller, the solver and the `rules` instance, and replaces the ad-hoc `solver_active` mux.

## Interface
- `N_REQ`, 3, number of requesters; index 0 = player, 1 = solver, 2 = challenge sequencer.
- `clk  in  1` — single clock.
- `reset  in  1` — synchronous, active-high.
- `cmd_valid  in  N_REQ` — per-requester command valid; must be held until accepted.
- `cmd_op  in  2*N_REQ` — per-requester op, slice i = bits [2i+1:2i]; 00 reset, 01 update, 10 erase, 11 reserved.
- `cmd_color  in  2*N_REQ` — per-requester color, same slicing.
- `cmd_ready  out  N_REQ` — accept strobe; a command transfers when valid && ready.
- `cmd_done  out  N_REQ` — 1-cycle pulse when the accepted command has settled.
- `cmd_rej  out  N_REQ` — asserted with `cmd_done` when the command was filtered.
- `lock_req  in  N_REQ` — level request for exclusive ownership.
- `lock_gnt  out  N_REQ` — one-hot or zero; current owner.
- `fsm_full  in  1`, `fsm_empty  in  1` — status from `rules`.
- `fsm_reset  out  1`, `fsm_update  out  1`, `fsm_erase  out  1` — registered 1-cycle command pulses to `rules`.
- `fsm_color  out  2` — registered; held between commands.

## Operation
- States:
  - IDLE: accepting.
  - SETTLE: one command in flight, nothing accepted.
- Owner register: NONE or index i; `lock_gnt` decodes it.
- IDLE, owner NONE, any `lock_req` high:
  - Acquire the highest-priority requester; priority 1 > 2 > 0.
  - No command is accepted that cycle.
- IDLE, owner i, `lock_req[i]` low: release to NONE; commands are still arbitrated that cycle under owner i.
- Lock changes occur only in IDLE. A request or drop during SETTLE waits.
- Command arbitration in IDLE:
  - Owner i: only requester i is eligible.
  - Owner NONE: round-robin among valid requesters, starting after the last winner. The pointer resets to N_REQ-1, so requester 0 is first.
- `cmd_ready` is combinational from state, owner, pointer and `cmd_valid`. It is at most one-hot and zero in SETTLE.
- Filter at accept, using `fsm_full`/`fsm_empty` sampled that cycle. A command is rejected when:
  - it is an update while full,
  - it is an erase while empty, or
  - it is op 11.
- Reset is never rejected.
- Accepted, non-rejected command: the matching `fsm_*` pulse and `fsm_color` are registered on the next cycle.
- Rejected command: no pulse is sent; it still occupies SETTLE.

## Timing
- Accept at cycle N.
- Command pulse at N+1, state SETTLE.
- `rules` status updates at the N+1 edge.
- `cmd_done[i]` (and `cmd_rej[i]`) pulse at N+2, state IDLE.
- A new accept is possible at N+2.
- Throughput is one command per 2 cycles.
- Reset values:
  - state IDLE, owner NONE, pointer N_REQ-1;
  - `cmd_done`, `cmd_rej`, `lock_gnt`, `fsm_update`, `fsm_erase` = 0;
  - `fsm_color` = 00;
  - `fsm_reset` = 1 while `reset` is high, so the checker is cleared together with the arbiter.
- The cycle after `reset` falls, `fsm_reset` = 0 and normal operation begins.
- Reset mid-SETTLE: the in-flight command is dropped, with no `cmd_done`.
- A requester dropping `cmd_valid` before acceptance is a protocol violation. It is flagged by an assertion in simulation, not handled.

## Structure
- Package `rules_pkg`:
  - op codes `OP_RESET`/`OP_UPDATE`/`OP_ERASE`/`OP_RSVD`;
  - requester ids `REQ_PLAYER`/`REQ_SOLVER`/`REQ_CHAL`;
  - `OWNER_NONE`;
  - the 2-bit color type.
- Sub-module `rr_pick`: combinational round-robin picker taking a mask and a pointer, returning a one-hot grant. It is reusable and tested standalone.
- The FSM, owner register, filter and output registers live in `rules_arbiter`.

## Test plan
- Reset, then requester 0 sends update color 10 with `fsm_full`=0: `cmd_ready[0]` high; `fsm_update`=1 with `fsm_color`=10 one cycle later; `cmd_done[0]`=1, `cmd_rej`=0 two cycles after accept.
- All three requesters assert update simultaneously and hold: accepts in order 0, 1, 2, 0, spaced 2 cycles apart.
- Requester 1 raises `lock_req` while 0 and 2 have commands valid: `lock_gnt`=010 next cycle; only requester 1 is served; 0 and 2 resume round-robin after `lock_req[1]` drops.
- Erase with `fsm_empty`=1: no `fsm_erase` pulse; `cmd_done`=`cmd_rej`=1 at N+2. Update with `fsm_full`=1 and op 11 give the same result.
- `reset` asserted during SETTLE: `fsm_reset`=1; no `cmd_done`; owner NONE; first accept after release goes to requester 0.
- `lock_req` for requesters 0 and 2 both asserted while idle: requester 2 is granted; 0 is granted only after 2 releases.
